// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// This package is also used by the ALU: states, ALU codes, opcodes and mux select encodings.
package riscv_mc_pkg;

  localparam int unsigned OP_W     = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ALUCTL_W = 4;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  // ALUControl codes, shared with the ALU
  localparam logic [ALUCTL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = 4'b1001;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [F3_W-1:0] F3_ADDSUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL    = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT    = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU   = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR    = 3'b100;
  localparam logic [F3_W-1:0] F3_SR     = 3'b101;
  localparam logic [F3_W-1:0] F3_OR     = 3'b110;
  localparam logic [F3_W-1:0] F3_AND    = 3'b111;
  localparam logic [F3_W-1:0] F3_BEQ    = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE    = 3'b001;

  localparam logic [SEL_W-1:0] SRCA_PC       = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1      = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_RS2      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b10;
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // Per-state control bundle driven onto the datapath
  typedef struct packed {
    logic             mem_req;
    logic             mem_write;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_op;
    logic             instr_done;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the coarse ALU operation plus funct fields to the 4-bit ALUControl code.
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [SEL_W-1:0]    i_alu_op,
  input  logic [F3_W-1:0]     i_funct3,
  input  logic                i_funct7b5,
  input  logic                i_op5,
  output logic [ALUCTL_W-1:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Op[5] separates R-type from OP-IMM so addi never turns into SUB
          F3_ADDSUB: o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLL:    o_alu_control = ALU_SLL;
          F3_SLT:    o_alu_control = ALU_SLT;
          F3_SLTU:   o_alu_control = ALU_SLTU;
          F3_XOR:    o_alu_control = ALU_XOR;
          F3_SR:     o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          F3_OR:     o_alu_control = ALU_OR;
          F3_AND:    o_alu_control = ALU_AND;
          default:   o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a shared-memory multi-cycle RV32I datapath.
// Outputs are decoded from the state register; FETCH/BRANCH/MEMWRITE also look at MemReady/Zero.
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic                CLK,
  input  logic                ResetPC,
  input  logic [OP_W-1:0]     Op,
  input  logic [F3_W-1:0]     funct3,
  input  logic                funct7b5,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                MemReq,
  output logic                MemWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [SEL_W-1:0]    ALUSrcA,
  output logic [SEL_W-1:0]    ALUSrcB,
  output logic [SEL_W-1:0]    ResultSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                InstrDone,
  output logic                Illegal
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_illegal;
  ctrl_t               w_ctrl;
  logic [ALUCTL_W-1:0] w_alu_control;

  always_ff @(posedge CLK or negedge ResetPC) begin
    if (!ResetPC) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sticky flag: ILLEGAL is absorbing, so only reset clears it
  always_ff @(posedge CLK or negedge ResetPC) begin
    if (!ResetPC) begin
      r_illegal <= 1'b0;
    end else if (w_state_nxt == S_ILLEGAL) begin
      r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: begin
        if (MemReady) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: w_state_nxt = S_MEMADR;
          OP_RTYPE:          w_state_nxt = S_EXECR;
          OP_ITYPE:          w_state_nxt = S_EXECI;
          OP_BRANCH:         w_state_nxt = S_BRANCH;
          OP_JAL:            w_state_nxt = S_JAL;
          default:           w_state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_state_nxt = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (MemReady) begin
          w_state_nxt = S_MEMWB;
        end
      end
      S_MEMWB:    w_state_nxt = S_FETCH;
      S_MEMWRITE: begin
        if (MemReady) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EXECR:    w_state_nxt = S_ALUWB;
      S_EXECI:    w_state_nxt = S_ALUWB;
      S_ALUWB:    w_state_nxt = S_FETCH;
      S_BRANCH:   w_state_nxt = S_FETCH;
      S_JAL:      w_state_nxt = S_ALUWB;
      S_ILLEGAL:  w_state_nxt = S_ILLEGAL;
      default:    w_state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.adr_src    = 1'b0;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALURESULT;
        w_ctrl.ir_write   = MemReady;
        w_ctrl.pc_write   = MemReady;
      end
      // Branch target PC-relative to OldPC, parked in ALUOut
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_MEMDATA;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.mem_write  = 1'b1;
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.instr_done = MemReady;
      end
      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_RS2;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a  = SRCA_RS1;
        w_ctrl.alu_src_b  = SRCB_RS2;
        w_ctrl.alu_op     = ALUOP_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.instr_done = 1'b1;
        case (funct3)
          F3_BEQ:  w_ctrl.pc_write = Zero;
          F3_BNE:  w_ctrl.pc_write = ~Zero;
          default: w_ctrl.pc_write = 1'b0;
        endcase
      end
      // Link value PC+4 is formed from OldPC; target already sits in ALUOut
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALUOP_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
      end
      S_ILLEGAL: w_ctrl = '0;
      default:   w_ctrl = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_ctrl.alu_op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (Op[5]),
    .o_alu_control (w_alu_control)
  );

  assign MemReq     = w_ctrl.mem_req;
  assign MemWrite   = w_ctrl.mem_write;
  assign AdrSrc     = w_ctrl.adr_src;
  assign IRWrite    = w_ctrl.ir_write;
  assign PCWrite    = w_ctrl.pc_write;
  assign RegWrite   = w_ctrl.reg_write;
  assign ALUSrcA    = w_ctrl.alu_src_a;
  assign ALUSrcB    = w_ctrl.alu_src_b;
  assign ResultSrc  = w_ctrl.result_src;
  assign ALUControl = w_alu_control;
  assign InstrDone  = w_ctrl.instr_done;
  assign Illegal    = r_illegal;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences a shared-memory, multi-cycle RISC-V RV32I datapath. It issues one memory request per instruction phase, steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable. It stalls on a memory ready handshake. It is the multi-cycle replacement for the single-cycle control path: same opcode/funct inputs, same 4-bit ALUControl encoding.

## Interface
- No parameters.
- CLK  in  1  clock; all state changes on rising edge.
- ResetPC  in  1  asynchronous, active-low reset; forces FETCH.
- Op  in  7  opcode from instruction register (IR[6:0]).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero  in  1  ALU zero flag, same cycle.
- MemReady  in  1  memory completes the current request this cycle.
- MemReq  out  1  memory request valid.
- MemWrite  out  1  request is a write.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU.
- InstrDone  out  1  one-cycle retire pulse.
- Illegal  out  1  sticky illegal-opcode flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; otherwise goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch target into ALUOut). Next state by Op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - any other value -> ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemReq=1, AdrSrc=1. Waits for MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Waits for MemReady, then FETCH with InstrDone=MemReady.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct-decoded ALU op. Then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct-decoded ALU op. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, InstrDone=1. Then FETCH.
  - PCWrite = Zero when funct3=000 (beq), ~Zero when funct3=001 (bne), 0 for any other funct3.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Then ALUWB.
- ILLEGAL: all enables 0, MemReq=0, Illegal=1. Absorbing; only reset exits.
- Funct decode (EXECR/EXECI), by funct3:
  - 000: SUB only when Op is R-type and funct7b5=1; otherwise ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRA if funct7b5=1, else SRL.
- Every enable not listed for a state is 0. Selects not listed are 00. ALUControl not listed is ADD.

## Timing
- Outputs are combinational from the state register. Exceptions: PCWrite also uses Zero; IRWrite and PCWrite in FETCH also use MemReady; ALUControl also uses funct3 and funct7b5.
- Reset: state=FETCH, Illegal=0. Outputs take their FETCH values, so MemReq=1 immediately after reset.
- Memory handshake:
  - A transaction completes on the rising edge where MemReq=1 and MemReady=1 together.
  - MemReq, MemWrite and AdrSrc stay stable until completion.
  - MemReady sampled while MemReq=0 is ignored.
- Latency with MemReady tied to 1: beq/bne 3 cycles; R, I, sw and jal 4 cycles; lw 5 cycles. Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset asserted mid-instruction: the FSM returns to FETCH asynchronously, with no partial RegWrite or MemWrite after release.

## Structure
- Shared package riscv_mc_pkg holds:
  - the state enum;
  - the ALUControl code constants (shared with the ALU);
  - the opcode constants;
  - the ALUSrcA, ALUSrcB and ResultSrc select encodings.
- One sub-module: alu_decoder, combinational. Inputs are ALUOp (00 add, 01 sub, 10 funct), funct3, funct7b5 and Op[5]. Output is ALUControl.

## Test plan
- add x3,x1,x2 with MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB. ALUControl=0000 in EXECR. RegWrite=1 only in cycle 4. InstrDone pulses once, in cycle 4.
- lw with MemReady held low 2 cycles in MEMREAD -> 7 cycles total. MemReq=1 and AdrSrc=1 stable through the wait. RegWrite=1 with ResultSrc=01 in MEMWB.
- beq with Zero=1, then Zero=0 -> PCWrite=1, then PCWrite=0, in BRANCH. Both take 3 cycles. bne (funct3=001) gives the inverse result.
- srai (Op=0010011, funct3=101, funct7b5=1) -> ALUControl=1000. addi with funct7b5=1 -> 0000, not SUB.
- Op=1111111 -> DECODE then ILLEGAL. Illegal=1 and MemReq=0 indefinitely. Asserting ResetPC=0 clears it to FETCH.
- ResetPC pulsed low while in MEMWRITE with MemReady=0 -> state becomes FETCH immediately. MemWrite drops to 0 without waiting for a clock edge.
